// File: rtl/spi_reg_target_pkg.sv
// spi_reg_target_pkg: shared FSM states, address map and frame length constants
package spi_reg_target_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  localparam logic [6:0] ADDR_STATUS = 7'd6;
  localparam logic [6:0] ADDR_ID = 7'd7;
  localparam int CMD_BITS = 8;
  localparam int DATA_BITS = 32;
  localparam int FRAME_BITS = CMD_BITS + DATA_BITS;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronises SPI pins into clk and derives SCK edge roles and select transitions
module spi_pin_sync (
  input  logic clk,
  input  logic rstn,
  input  logic cpol,
  input  logic spi_sck,
  input  logic spi_ssn,
  input  logic spi_mosi,
  output logic lead_pulse,
  output logic trail_pulse,
  output logic ssn_fall,
  output logic ssn_rise,
  output logic ssn_s,
  output logic mosi_s
);
  logic [2:0] r_sck, r_ssn;
  logic [1:0] r_mosi;
  logic w_sck_chg;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sck  <= '0;
      r_ssn  <= '1;
      r_mosi <= '0;
    end else begin
      r_sck  <= {r_sck[1:0], spi_sck};
      r_ssn  <= {r_ssn[1:0], spi_ssn};
      r_mosi <= {r_mosi[0], spi_mosi};
    end
  end
  assign w_sck_chg   = r_sck[1] ^ r_sck[2];
  assign lead_pulse  = w_sck_chg && (r_sck[1] != cpol);
  assign trail_pulse = w_sck_chg && (r_sck[1] == cpol);
  assign ssn_fall    = r_ssn[2] && !r_ssn[1];
  assign ssn_rise    = !r_ssn[2] && r_ssn[1];
  assign ssn_s       = r_ssn[1];
  assign mosi_s      = r_mosi[1];
endmodule

// File: rtl/spi_reg_target.sv
// spi_reg_target: oversampled SPI target exposing a small 32-bit register file
module spi_reg_target
  import spi_reg_target_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h5350_4931,
  parameter int NREGS_RW = 6
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cpol,
  input  logic                     cpha,
  input  logic                     spi_sck,
  input  logic                     spi_ssn,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_misooen,
  input  logic [31:0]              status_i,
  output logic [NREGS_RW*32-1:0]   regs_o,
  output logic                     wr_strobe,
  output logic [2:0]               wr_addr,
  output logic                     frame_err
);
  state_t r_state, w_state_n;
  logic w_lead, w_trail, w_fall, w_rise, w_ssn_s, w_mosi_s;
  logic w_samp, w_shift, w_cmd_last, w_data_last;
  logic [5:0] r_cnt;
  logic [31:0] r_sh, r_tx, w_word;
  logic [7:0] r_cmd;
  logic [NREGS_RW-1:0][31:0] r_regs;
  logic r_load, r_commit, r_miso, r_strobe, r_err;
  logic [2:0] r_wr_addr;
  spi_pin_sync u_sync (
    .clk(clk), .rstn(rstn), .cpol(cpol), .spi_sck(spi_sck), .spi_ssn(spi_ssn), .spi_mosi(spi_mosi),
    .lead_pulse(w_lead), .trail_pulse(w_trail), .ssn_fall(w_fall), .ssn_rise(w_rise),
    .ssn_s(w_ssn_s), .mosi_s(w_mosi_s)
  );
  // a select rise in the same clk as an SCK edge wins: the edge is dropped
  assign w_samp      = (r_state == CMD || r_state == DATA) && !w_rise && (cpha ? w_trail : w_lead);
  assign w_shift     = r_state == DATA && !w_rise && (cpha ? w_lead : w_trail);
  assign w_cmd_last  = r_state == CMD && w_samp && r_cnt == 6'(CMD_BITS - 1);
  assign w_data_last = r_state == DATA && w_samp && r_cnt == 6'(FRAME_BITS - 1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else r_state <= w_state_n;
  end
  always_comb begin
    w_state_n = r_state;
    if (w_rise) w_state_n = IDLE;
    else if (r_state == IDLE && w_fall) w_state_n = CMD;
    else if (w_cmd_last) w_state_n = DATA;
    else if (w_data_last) w_state_n = DONE;
  end
  // r_sh[6:0] holds the address in the clk the command completes
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NREGS_RW; i++) if (r_sh[6:0] == 7'(i)) w_word = r_regs[i];
    if (r_sh[6:0] == ADDR_STATUS) w_word = status_i;
    if (r_sh[6:0] == ADDR_ID) w_word = ID_VALUE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_sh      <= '0;
      r_tx      <= '0;
      r_cmd     <= '0;
      r_regs    <= '0;
      r_load    <= 1'b0;
      r_commit  <= 1'b0;
      r_miso    <= 1'b0;
      r_strobe  <= 1'b0;
      r_err     <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_cnt    <= (w_rise || r_state == IDLE) ? '0 : r_cnt + 6'(w_samp);
      r_sh     <= w_samp ? {r_sh[30:0], w_mosi_s} : r_sh;
      r_load   <= w_cmd_last;
      r_commit <= w_data_last && r_cmd[7] && r_cmd[6:0] < 7'(NREGS_RW);
      r_err    <= (w_rise && r_cnt != '0 && r_cnt < 6'(FRAME_BITS)) || (r_load && r_sh[6:0] > ADDR_ID);
      r_strobe <= r_commit;
      r_miso   <= w_fall ? 1'b0 : w_shift ? r_tx[31] : r_miso;
      if (r_load) begin
        r_cmd <= r_sh[7:0];
        r_tx  <= r_sh[7] ? '0 : w_word;
      end else if (w_shift) r_tx <= {r_tx[30:0], 1'b0};
      if (r_commit) r_wr_addr <= r_cmd[2:0];
      for (int i = 0; i < NREGS_RW; i++) if (r_commit && r_cmd[2:0] == 3'(i)) r_regs[i] <= r_sh;
    end
  end
  assign spi_miso    = r_miso && r_state == DATA;
  assign spi_misooen = w_ssn_s;
  assign regs_o      = r_regs;
  assign wr_strobe   = r_strobe;
  assign wr_addr     = r_wr_addr;
  assign frame_err   = r_err;
endmodule

// File: tb/tb_spi_reg_target.sv
// tb_spi_reg_target: random SPI master with a register-file model and a scoreboard monitor
module tb_spi_reg_target;
  localparam logic [31:0] ID = 32'h5350_4931;
  logic clk = 0, rstn = 0, cpol = 0, cpha = 0, spi_sck = 0, spi_ssn = 1, spi_mosi = 0;
  logic spi_miso, spi_misooen, wr_strobe, frame_err;
  logic [31:0] status_i = '0;
  logic [191:0] regs_o;
  logic [2:0] wr_addr;
  int n_tests = 0, n_fail = 0;
  logic [31:0] m_regs [6];
  typedef struct { logic [2:0] a; logic [31:0] d; } wr_t;
  wr_t exp_wr[$];
  logic [31:0] exp_rd[$], got_rd[$];
  int exp_err[$];

  always #5 clk = ~clk;

  spi_reg_target dut (
    .clk(clk), .rstn(rstn), .cpol(cpol), .cpha(cpha), .spi_sck(spi_sck), .spi_ssn(spi_ssn),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_misooen(spi_misooen), .status_i(status_i),
    .regs_o(regs_o), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  function automatic void check(string nm, logic [191:0] act, logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [191:0] model_vec();
    logic [191:0] v;
    for (int i = 0; i < 6; i++) v[i*32 +: 32] = m_regs[i];
    return v;
  endfunction

  function automatic void check_reset_values();
    check("rst regs_o", regs_o, '0);
    check("rst wr_strobe", wr_strobe, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst frame_err", frame_err, 0);
    check("rst spi_miso", spi_miso, 0);
    check("rst spi_misooen", spi_misooen, 1);
  endfunction

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  // Drives one select window of nbits SCK cycles; rst_mid pulls reset after 20 bits instead of ending normally
  task automatic frame(input bit pol, input bit pha, input logic [7:0] cmd, input logic [31:0] data,
                       input int nbits, input bit rst_mid = 0);
    logic [39:0] bits;
    logic [31:0] rx, e;
    logic [6:0] a;
    logic b;
    bit full;
    bits = {cmd, data};
    rx = '0;
    a = cmd[6:0];
    full = nbits >= 40;
    if (!rst_mid) begin
      if (nbits > 0 && nbits < 40) exp_err.push_back(nbits);
      if (nbits >= 8 && a > 7) exp_err.push_back(a);
      if (full && cmd[7] && a < 6) begin
        m_regs[a] = data;
        exp_wr.push_back('{a: a[2:0], d: data});
      end
      if (full && !cmd[7]) begin
        e = '0;
        if (a < 6) e = m_regs[a];
        else if (a == 6) e = status_i;
        else if (a == 7) e = ID;
        exp_rd.push_back(e);
      end
    end
    cpol = pol;
    cpha = pha;
    spi_sck = pol;
    repeat (6) @(negedge clk);
    spi_ssn = 0;
    for (int i = 0; i < nbits && !(rst_mid && i == 20); i++) begin
      b = (i < 40) ? bits[39 - i] : 1'($urandom);
      if (!pha) begin
        spi_mosi = b;
        half();
        spi_sck = ~pol;
        if (i >= 8 && i < 40) rx = {rx[30:0], spi_miso};
        half();
        spi_sck = pol;
      end else begin
        half();
        spi_sck = ~pol;
        spi_mosi = b;
        half();
        if (i >= 8 && i < 40) rx = {rx[30:0], spi_miso};
        spi_sck = pol;
      end
      if (i == 4) check("misooen in frame", spi_misooen, 0);
    end
    if (rst_mid) begin
      rstn = 0;
      spi_ssn = 1;
      spi_sck = pol;
      spi_mosi = 0;
    end else begin
      half();
      spi_ssn = 1;
      if (full && !cmd[7]) got_rd.push_back(rx);
      repeat (12) @(negedge clk);
    end
  endtask

  initial begin : monitor
    wr_t w;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        if (exp_wr.size() == 0) check("wr_strobe unexpected", wr_strobe, 0);
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", wr_addr, w.a);
          check("written word", regs_o[w.a*32 +: 32], w.d);
          check("regs_o after write", regs_o, model_vec());
        end
      end
      if (frame_err) begin
        if (exp_err.size() == 0) check("frame_err unexpected", frame_err, 0);
        else void'(exp_err.pop_front());
      end
      if (got_rd.size() > 0) begin
        r = got_rd.pop_front();
        if (exp_rd.size() == 0) check("read unexpected", r, 'x);
        else check("read data", r, exp_rd.pop_front());
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] a;
    int nb, r;
    for (int i = 0; i < 6; i++) m_regs[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rstn = 1;
    repeat (4) @(negedge clk);
    frame(0, 0, 8'h82, 32'hDEADBEEF, 40);
    frame(0, 1, 8'h07, 32'h0, 40);
    frame(1, 0, 8'h07, 32'h0, 40);
    frame(1, 1, 8'h07, 32'h0, 40);
    frame(0, 1, 8'h02, 32'h0, 40);
    frame(1, 0, 8'h02, 32'h0, 40);
    frame(1, 1, 8'h02, 32'h0, 40);
    status_i = 32'h0000_00A5;
    frame(0, 0, 8'h06, 32'h0, 40);
    frame(0, 0, 8'h86, 32'hFFFFFFFF, 40);
    check("regs after write to status", regs_o, model_vec());
    frame(0, 0, 8'h81, 32'h1234_5678, 20);
    check("regs after aborted write", regs_o, model_vec());
    frame(0, 0, 8'h81, 32'hCAFE_F00D, 40);
    frame(0, 0, 8'h90, 32'h0000_0001, 40);
    frame(0, 0, 8'h10, 32'h0, 40);
    frame(0, 0, 8'h03, 32'h0, 0);
    frame(1, 1, 8'h85, 32'h0BAD_F00D, 44);
    frame(0, 1, 8'h05, 32'h0, 43);
    for (int k = 0; k < 30; k++) begin
      a = ($urandom_range(0, 9) == 9) ? 7'($urandom_range(8, 127)) : 7'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      nb = (r == 0) ? $urandom_range(0, 39) : (r == 1) ? $urandom_range(41, 44) : 40;
      status_i = $urandom;
      frame(1'($urandom), 1'($urandom), {1'($urandom), a}, $urandom, nb);
    end
    check("regs after random frames", regs_o, model_vec());
    frame(0, 0, 8'h80, 32'h1111_2222, 40, 1);
    #1;
    check_reset_values();
    for (int i = 0; i < 6; i++) m_regs[i] = '0;
    @(negedge clk);
    rstn = 1;
    repeat (6) @(negedge clk);
    frame(0, 0, 8'h80, 32'h3333_4444, 40);
    frame(0, 0, 8'h00, 32'h0, 40);
    repeat (20) @(negedge clk);
    check("pending writes", exp_wr.size(), 0);
    check("pending frame errors", exp_err.size(), 0);
    check("pending reads", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
